// File: rtl/regfile_wr_sched.sv
// rtl/regfile_wr_sched.sv - register-file write-port scheduler: ex/mem round-robin arbitration with XZR write suppression
// Define REGFILE_CLEAR_EN to compile in the post-reset sweep that zeroes X0..X30.
module regfile_wr_sched #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              clear_busy,
  output logic              conflict
);

  localparam logic [ADDR_W-1:0] XZR = {ADDR_W{1'b1}};

  logic              run;
  logic              prio;
  logic              both;
  logic              ex_acc;
  logic              mem_acc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef REGFILE_CLEAR_EN
  localparam logic [0:0]        ST_RUN   = 1'b0;
  localparam logic [0:0]        ST_CLEAR = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_cnt;

  // Sweep stops one short of XZR, which never holds a value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      sweep_cnt <= sweep_cnt + CNT_ONE;
      if (sweep_cnt == LAST_IDX) begin
        state <= ST_RUN;
      end
    end
  end

  assign run        = (state == ST_RUN);
  assign clear_busy = (state == ST_CLEAR);
`else
  assign run        = 1'b1;
  assign clear_busy = 1'b0;
`endif

  assign both      = ex_valid && mem_valid;
  assign ex_ready  = run && ex_valid && (!mem_valid || !prio);
  assign mem_ready = run && mem_valid && (!ex_valid || prio);
  assign ex_acc    = ex_valid && ex_ready;
  assign mem_acc   = mem_valid && mem_ready;
  assign sel_addr  = mem_acc ? mem_addr : ex_addr;
  assign sel_data  = mem_acc ? mem_data : ex_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef REGFILE_CLEAR_EN
    end else if (state == ST_CLEAR) begin
      wr_en   <= 1'b1;
      wr_addr <= sweep_cnt;
      wr_data <= '0;
`endif
    end else if (ex_acc || mem_acc) begin
      // XZR requests complete the handshake but leave the write port untouched.
      if (sel_addr != XZR) begin
        wr_en   <= 1'b1;
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end else begin
        wr_en <= 1'b0;
      end
    end else begin
      wr_en <= 1'b0;
    end
  end

  // Round-robin: on contention the pointer moves to the requester that lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      conflict <= run && both;
      if (run && both) begin
        prio <= ~prio;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb/tb_regfile_wr_sched.sv - directed self-checking bench for regfile_wr_sched
// Follows REGFILE_CLEAR_EN to choose between the sweep and no-sweep scenarios.
module tb_regfile_wr_sched;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

`ifdef REGFILE_CLEAR_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_data;
  logic              ex_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear_busy;
  logic              conflict;

  int checks = 0;
  int errors = 0;

  regfile_wr_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_busy(clear_busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_valid  = 1'b0;
    ex_addr   = '0;
    ex_data   = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
  endtask

  task automatic release_reset;
    step;
    reset_n = 1'b1;
  endtask

  task automatic wait_run;
    int n;
    n = 0;
    while (clear_busy === 1'b1 && n < 40) begin
      step;
      n++;
    end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL wait_run: clear_busy=%b required 0 within 40 cycles", clear_busy); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle_inputs;
    #2;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %h required 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b required 0", conflict); end
    checks++; if (clear_busy !== EXP_BUSY_RST) begin errors++; $display("FAIL reset_clear_busy: got %b required %b", clear_busy, EXP_BUSY_RST); end
    checks++; if (ex_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got ex=%b mem=%b required 0 0", ex_ready, mem_ready); end
  endtask

`ifdef REGFILE_CLEAR_EN
  task automatic test_sweep;
    release_reset;
    ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 64'h77;
    #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL sweep_ready_c0: got %b required 0", ex_ready); end
    for (int i = 0; i < 31; i++) begin
      step;
      checks++; if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(i) || wr_data !== '0) begin errors++; $display("FAIL sweep_write[%0d]: got en=%b addr=%0d data=%h required 1 %0d 0", i, wr_en, wr_addr, wr_data, i); end
      checks++; if (clear_busy !== (i < 30)) begin errors++; $display("FAIL sweep_busy[%0d]: got %b required %b", i, clear_busy, (i < 30)); end
      checks++; if (ex_ready !== (i == 30)) begin errors++; $display("FAIL sweep_ready[%0d]: got %b required %b", i, ex_ready, (i == 30)); end
    end
    step;
    ex_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 64'h77) begin errors++; $display("FAIL sweep_first_run_write: got en=%b addr=%0d data=%h required 1 7 77", wr_en, wr_addr, wr_data); end
    step;
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd7) begin errors++; $display("FAIL sweep_idle_after: got en=%b addr=%0d required 0 7", wr_en, wr_addr); end
  endtask
`else
  task automatic test_first_cycle;
    release_reset;
    ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 64'h33;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL first_cycle_ready: got %b required 1", ex_ready); end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL first_cycle_busy: got %b required 0", clear_busy); end
    step;
    ex_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 64'h33) begin errors++; $display("FAIL first_cycle_write: got en=%b addr=%0d data=%h required 1 3 33", wr_en, wr_addr, wr_data); end
    step;
    checks++; if (wr_en !== 1'b0 || clear_busy !== 1'b0) begin errors++; $display("FAIL first_cycle_idle: got en=%b busy=%b required 0 0", wr_en, clear_busy); end
  endtask
`endif

  task automatic test_single_ex;
    ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 64'hDEAD;
    #1;
    checks++; if (ex_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL single_ex_ready: got ex=%b mem=%b required 1 0", ex_ready, mem_ready); end
    step;
    ex_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hDEAD) begin errors++; $display("FAIL single_ex_write: got en=%b addr=%0d data=%h required 1 5 dead", wr_en, wr_addr, wr_data); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL single_ex_conflict: got %b required 0", conflict); end
    #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL single_ex_ready_no_valid: got %b required 0", ex_ready); end
  endtask

  task automatic test_back_to_back;
    logic exp_ex;
    ex_valid  = 1'b1; ex_addr  = 5'd10; ex_data  = 64'hA0;
    mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 64'hB0;
    for (int k = 0; k < 4; k++) begin
      exp_ex = (k % 2 == 0);
      #1;
      checks++; if (ex_ready !== exp_ex || mem_ready !== !exp_ex) begin errors++; $display("FAIL b2b_grant[%0d]: got ex=%b mem=%b required %b %b", k, ex_ready, mem_ready, exp_ex, !exp_ex); end
      step;
      checks++; if (wr_en !== 1'b1 || wr_addr !== (exp_ex ? 5'd10 : 5'd11) || wr_data !== (exp_ex ? 64'hA0 : 64'hB0)) begin errors++; $display("FAIL b2b_write[%0d]: got en=%b addr=%0d data=%h", k, wr_en, wr_addr, wr_data); end
      checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL b2b_conflict[%0d]: got %b required 1", k, conflict); end
    end
    idle_inputs;
    step;
    checks++; if (conflict !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 5'd11) begin errors++; $display("FAIL b2b_after: got conflict=%b en=%b addr=%0d required 0 0 11", conflict, wr_en, wr_addr); end
  endtask

  task automatic test_same_reg;
    ex_valid  = 1'b1; ex_addr  = 5'd9; ex_data  = 64'h1;
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 64'h2;
    #1;
    checks++; if (ex_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL same_reg_grant: got ex=%b mem=%b required 1 0", ex_ready, mem_ready); end
    step;
    ex_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 64'h1) begin errors++; $display("FAIL same_reg_first: got en=%b addr=%0d data=%h required 1 9 1", wr_en, wr_addr, wr_data); end
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL same_reg_mem_ready: got %b required 1", mem_ready); end
    step;
    mem_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 64'h2) begin errors++; $display("FAIL same_reg_last: got en=%b addr=%0d data=%h required 1 9 2", wr_en, wr_addr, wr_data); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL same_reg_conflict: got %b required 0", conflict); end
  endtask

  task automatic test_xzr;
    ex_valid = 1'b1; ex_addr = 5'd4; ex_data = 64'h44;
    step;
    ex_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd4) begin errors++; $display("FAIL xzr_prior_write: got en=%b addr=%0d required 1 4", wr_en, wr_addr); end
    mem_valid = 1'b1; mem_addr = 5'd31; mem_data = 64'h1;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL xzr_ready: got %b required 1", mem_ready); end
    step;
    mem_valid = 1'b0;
    checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd4 || wr_data !== 64'h44) begin errors++; $display("FAIL xzr_suppress: got en=%b addr=%0d data=%h required 0 4 44", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_async_reset;
`ifdef REGFILE_CLEAR_EN
    reset_n = 1'b0;
    release_reset;
    for (int i = 0; i < 13; i++) step;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd12) begin errors++; $display("FAIL areset_at_idx12: got en=%b addr=%0d required 1 12", wr_en, wr_addr); end
`else
    ex_valid = 1'b1; ex_addr = 5'd6; ex_data = 64'h66;
    step;
    ex_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd6) begin errors++; $display("FAIL areset_pre_write: got en=%b addr=%0d required 1 6", wr_en, wr_addr); end
`endif
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || conflict !== 1'b0) begin errors++; $display("FAIL areset_zero: got en=%b addr=%0d data=%h conflict=%b required all 0", wr_en, wr_addr, wr_data, conflict); end
    checks++; if (clear_busy !== EXP_BUSY_RST) begin errors++; $display("FAIL areset_busy: got %b required %b", clear_busy, EXP_BUSY_RST); end
    release_reset;
`ifdef REGFILE_CLEAR_EN
    step;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd0) begin errors++; $display("FAIL areset_restart0: got en=%b addr=%0d required 1 0", wr_en, wr_addr); end
    step;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd1) begin errors++; $display("FAIL areset_restart1: got en=%b addr=%0d required 1 1", wr_en, wr_addr); end
`endif
    wait_run;
    ex_valid  = 1'b1; ex_addr  = 5'd12; ex_data  = 64'hC0;
    mem_valid = 1'b1; mem_addr = 5'd13; mem_data = 64'hD0;
    #1;
    checks++; if (ex_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL areset_prio: got ex=%b mem=%b required 1 0", ex_ready, mem_ready); end
    step;
    idle_inputs;
    checks++; if (wr_addr !== 5'd12 || wr_data !== 64'hC0 || conflict !== 1'b1) begin errors++; $display("FAIL areset_post_write: got addr=%0d data=%h conflict=%b required 12 c0 1", wr_addr, wr_data, conflict); end
    step;
  endtask

  initial begin
    test_reset;
`ifdef REGFILE_CLEAR_EN
    test_sweep;
`else
    test_first_cycle;
`endif
    test_single_ex;
    test_back_to_back;
    test_same_reg;
    test_xzr;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
